bitfusion_mac_seq: RTL and testbench

- Sequential, precision-configurable multiply-accumulate unit; the successor of bitfusion_top.
- Each operand word is DATA_W bits and packs several lanes at the configured precision. Each accepted beat adds the dot product of its lanes to an accumulator.
- Operand widths above CORE_W are handled temporally: the CORE_W fused core runs over several passes.
- in_last closes a vector. The sum is then presented on a valid/ready output, and the accumulator clears.

---
 rtl/bitfusion_pkg.sv | 64 ++++++
 rtl/bitfusion_fused_core.sv | 102 ++++++++++
 rtl/bitfusion_mac_seq.sv | 158 +++++++++++++++
 tb/tb_bitfusion_mac_seq.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitfusion_pkg.sv
// Shared types and lookups for the bit-fusion sequential MAC.
// Holds the FSM state type, legal width encodings and the pass schedule
// (how many passes a beat needs, which chunks each pass uses, and its shift).
package bitfusion_pkg;

  // Controller states: idle waiting for a beat, or executing passes.
  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // Legal element width encodings (value equals the bit width).
  localparam logic [4:0] WIDTH_1  = 5'd1;
  localparam logic [4:0] WIDTH_2  = 5'd2;
  localparam logic [4:0] WIDTH_4  = 5'd4;
  localparam logic [4:0] WIDTH_8  = 5'd8;
  localparam logic [4:0] WIDTH_16 = 5'd16;

  // A width is usable if it is one of the encodings and fits the operand word.
  function automatic logic is_legal_width(input logic [4:0] w, input int data_w);
    logic known;
    known = (w == WIDTH_1) || (w == WIDTH_2) || (w == WIDTH_4) ||
            (w == WIDTH_8) || (w == WIDTH_16);
    return known && (int'(w) <= data_w);
  endfunction

  // Number of temporal passes: each operand wider than the core doubles it.
  function automatic logic [2:0] pass_count(input logic [4:0] iw, input logic [4:0] ww,
                                            input int core_w);
    logic a_split;
    logic w_split;
    logic [2:0] n;
    a_split = int'(iw) > core_w;
    w_split = int'(ww) > core_w;
    case ({a_split, w_split})
      2'b11:   n = 3'd4;
      2'b10:   n = 3'd2;
      2'b01:   n = 3'd2;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

  // Chunk selection {act_hi, wgt_hi} for a pass index. The full schedule is
  // lo*lo, lo*hi, hi*lo, hi*hi; combinations that do not apply are skipped,
  // so a single split operand just toggles its own hi bit.
  function automatic logic [1:0] pass_chunks(input logic [1:0] pass, input logic a_split,
                                             input logic w_split);
    logic [1:0] c;
    case ({a_split, w_split})
      2'b11:   c = pass;
      2'b10:   c = {pass[0], 1'b0};
      2'b01:   c = {1'b0, pass[0]};
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  // Left shift of a pass partial: one core width per hi chunk involved.
  function automatic logic [5:0] pass_shift(input logic [1:0] chunks, input int core_w);
    return 6'((int'(chunks[1]) + int'(chunks[0])) * core_w);
  endfunction

endpackage

// File: rtl/bitfusion_fused_core.sv
// Combinational lane multiply-reduce: per-lane CORE_W x CORE_W products summed.
// Zero latency (pure combinational).
// No flow control; the caller holds operands stable for the pass.
module bitfusion_fused_core
  import bitfusion_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CORE_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_weight,
  input  logic [4:0]        i_in_width,
  input  logic [4:0]        i_weight_width,
  input  logic              i_s_in,
  input  logic              i_s_weight,
  input  logic              i_a_hi,
  input  logic              i_w_hi,
  output logic [ACC_W-1:0]  o_partial
);

  localparam int EW = 2 * CORE_W;
  localparam int PW = 2 * CORE_W + 2;

  // Extract the element starting at bit 'off', keep its low 'width' bits and
  // extend it to two core widths (sign or zero) so either chunk can be taken.
  function automatic logic [EW-1:0] extract(input logic [DATA_W-1:0] word, input int off,
                                            input logic [4:0] width, input logic sgn);
    logic [DATA_W-1:0]    sh;
    logic [EW+DATA_W-1:0] shp;
    logic                 msb;
    logic [EW-1:0]        r;
    sh  = word >> off;
    shp = {{EW{1'b0}}, sh};
    msb = 1'b0;
    for (int b = 0; b < DATA_W; b++) begin
      if (width == 5'(b + 1)) msb = sh[b];
    end
    for (int b = 0; b < EW; b++) begin
      r[b] = (5'(b) < width) ? shp[b] : (sgn & msb);
    end
    return r;
  endfunction

  // One CORE_W x CORE_W product; each side independently signed or unsigned.
  function automatic logic [ACC_W-1:0] mul_chunk(input logic [CORE_W-1:0] a, input logic sa,
                                                 input logic [CORE_W-1:0] b, input logic sb);
    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] bx;
    logic signed [PW-1:0] p;
    ax = $signed({{(PW-CORE_W){sa & a[CORE_W-1]}}, a});
    bx = $signed({{(PW-CORE_W){sb & b[CORE_W-1]}}, b});
    p  = ax * bx;
    return {{(ACC_W-PW){p[PW-1]}}, p};
  endfunction

  logic [4:0]       w_slot;
  logic             w_legal;
  logic             w_a_split;
  logic             w_w_split;
  int               w_off;
  logic [EW-1:0]    w_ea;
  logic [EW-1:0]    w_eb;
  logic [CORE_W-1:0] w_ca;
  logic [CORE_W-1:0] w_cb;
  logic             w_sa;
  logic             w_sb;
  logic [ACC_W-1:0] w_acc;

  assign w_slot    = (i_in_width > i_weight_width) ? i_in_width : i_weight_width;
  assign w_legal   = is_legal_width(i_in_width, DATA_W) && is_legal_width(i_weight_width, DATA_W);
  assign w_a_split = int'(i_in_width) > CORE_W;
  assign w_w_split = int'(i_weight_width) > CORE_W;

  // Sum lane products. An unsplit operand is its whole element, signed by its
  // flag; a split operand contributes an unsigned lo chunk or a flag-signed hi chunk.
  always_comb begin
    w_acc = '0;
    w_off = 0;
    w_ea  = '0;
    w_eb  = '0;
    w_ca  = '0;
    w_cb  = '0;
    w_sa  = 1'b0;
    w_sb  = 1'b0;
    for (int k = 0; k < DATA_W; k++) begin
      w_off = k * int'(w_slot);
      if (w_legal && (w_off < DATA_W)) begin
        w_ea  = extract(i_data, w_off, i_in_width, i_s_in);
        w_eb  = extract(i_weight, w_off, i_weight_width, i_s_weight);
        w_ca  = (w_a_split && i_a_hi) ? w_ea[EW-1:CORE_W] : w_ea[CORE_W-1:0];
        w_cb  = (w_w_split && i_w_hi) ? w_eb[EW-1:CORE_W] : w_eb[CORE_W-1:0];
        w_sa  = w_a_split ? (i_a_hi & i_s_in) : i_s_in;
        w_sb  = w_w_split ? (i_w_hi & i_s_weight) : i_s_weight;
        w_acc = w_acc + mul_chunk(w_ca, w_sa, w_cb, w_sb);
      end
    end
  end

  assign o_partial = w_legal ? w_acc : '0;

endmodule

// File: rtl/bitfusion_mac_seq.sv
// Precision-configurable sequential MAC: packed-lane dot products accumulated per vector.
// Latency: a last beat accepted at edge k yields out_valid after edge k+passes.
// Backpressure: in_ready drops during non-final passes and while a result is unconsumed.
module bitfusion_mac_seq
  import bitfusion_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CORE_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  input  logic [4:0]        in_width,
  input  logic [4:0]        weight_width,
  input  logic              s_in,
  input  logic              s_weight,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              cfg_err
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_pass;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_weight;
  logic [4:0]        r_iw;
  logic [4:0]        r_ww;
  logic              r_s_in;
  logic              r_s_w;
  logic              r_last;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_out_acc;
  logic              r_out_valid;
  logic              r_cfg_err;

  logic [2:0]        w_passes;
  logic              w_final;
  logic              w_out_blocked;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_in_legal;
  logic [1:0]        w_chunks;
  logic [5:0]        w_shift;
  logic [ACC_W-1:0]  w_partial;
  logic [ACC_W-1:0]  w_sum;

  assign w_passes      = pass_count(r_iw, r_ww, CORE_W);
  assign w_final       = (r_state == EXEC) && ({1'b0, r_pass} == (w_passes - 3'd1));
  assign w_out_blocked = r_out_valid && !out_ready;
  // Reset gating keeps in_ready low while rst_n is asserted.
  assign w_in_ready    = rst_n && ((r_state == IDLE) || w_final) && !w_out_blocked;
  assign w_accept      = in_valid && w_in_ready;
  assign w_in_legal    = is_legal_width(in_width, DATA_W) && is_legal_width(weight_width, DATA_W);
  assign w_chunks      = pass_chunks(r_pass, int'(r_iw) > CORE_W, int'(r_ww) > CORE_W);
  assign w_shift       = pass_shift(w_chunks, CORE_W);
  assign w_sum         = r_acc + (w_partial << w_shift);

  bitfusion_fused_core #(
    .DATA_W(DATA_W),
    .CORE_W(CORE_W),
    .ACC_W (ACC_W)
  ) u_core (
    .i_data        (r_data),
    .i_weight      (r_weight),
    .i_in_width    (r_iw),
    .i_weight_width(r_ww),
    .i_s_in        (r_s_in),
    .i_s_weight    (r_s_w),
    .i_a_hi        (w_chunks[1]),
    .i_w_hi        (w_chunks[0]),
    .o_partial     (w_partial)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: a beat accepted on the final pass restarts execution directly.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXEC;
      EXEC:    if (w_final)  w_state_nxt = w_accept ? EXEC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the beat's operands and configuration on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_weight <= '0;
      r_iw     <= '0;
      r_ww     <= '0;
      r_s_in   <= 1'b0;
      r_s_w    <= 1'b0;
      r_last   <= 1'b0;
    end else if (w_accept) begin
      r_data   <= in_data;
      r_weight <= in_weight;
      r_iw     <= in_width;
      r_ww     <= weight_width;
      r_s_in   <= s_in;
      r_s_w    <= s_weight;
      r_last   <= in_last;
    end
  end

  // Pass counter: advances each EXEC cycle, returns to 0 after the final pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_pass <= '0;
    else if (r_state == EXEC)   r_pass <= w_final ? 2'd0 : r_pass + 2'd1;
  end

  // Accumulator: adds each shifted partial; the final pass of a last beat
  // hands the sum to the output register and clears for the next vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_out_acc <= '0;
    end else if (r_state == EXEC) begin
      if (w_final && r_last) begin
        r_out_acc <= w_sum;
        r_acc     <= '0;
      end else begin
        r_acc     <= w_sum;
      end
    end
  end

  // Output valid: a newly produced result wins over a same-cycle consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_out_valid <= 1'b0;
    else if ((r_state == EXEC) && w_final && r_last) r_out_valid <= 1'b1;
    else if (out_ready)                        r_out_valid <= 1'b0;
  end

  // Configuration error pulse, one cycle after an accepted illegal beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cfg_err <= 1'b0;
    else        r_cfg_err <= w_accept && !w_in_legal;
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_bitfusion_mac_seq.sv
// Self-checking bench for bitfusion_mac_seq with a lane-level arithmetic reference model.
module tb_bitfusion_mac_seq;

  localparam int DATA_W = 16;
  localparam int CORE_W = 8;
  localparam int ACC_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [DATA_W-1:0] in_weight = '0;
  logic [4:0]        in_width = 5'd8;
  logic [4:0]        weight_width = 5'd8;
  logic              s_in = 1'b0;
  logic              s_weight = 1'b0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ACC_W-1:0]  out_acc;
  logic              cfg_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bitfusion_mac_seq #(.DATA_W(DATA_W), .CORE_W(CORE_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight), .in_width(in_width),
    .weight_width(weight_width), .s_in(s_in), .s_weight(s_weight),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic bit model_legal(input int w);
    return (w == 1 || w == 2 || w == 4 || w == 8 || w == 16) && (w <= DATA_W);
  endfunction

  function automatic int model_passes(input int iw, input int ww);
    return ((iw > CORE_W) ? 2 : 1) * ((ww > CORE_W) ? 2 : 1);
  endfunction

  function automatic longint elem_val(input logic [15:0] word, input int off, input int w,
                                      input bit sgn);
    longint v;
    v = longint'(word >> off) & ((longint'(1) << w) - 1);
    if (sgn && (((v >> (w - 1)) & 1) == 1)) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic logic [31:0] model_dot(input logic [15:0] d, input logic [15:0] wt,
                                            input int iw, input int ww, input bit sa, input bit sw);
    longint sum;
    int slot;
    if (!model_legal(iw) || !model_legal(ww)) return 32'd0;
    slot = (iw > ww) ? iw : ww;
    sum = 0;
    for (int k = 0; k < DATA_W / slot; k++)
      sum += elem_val(d, k * slot, iw, sa) * elem_val(wt, k * slot, ww, sw);
    return sum[31:0];
  endfunction

  // ---------------- stimulus helpers (start and end on a negedge) ----------------
  task automatic send_beat(input logic [15:0] d, input logic [15:0] wt, input int iw,
                           input int ww, input bit sa, input bit sw, input bit last,
                           output int k, output int waits);
    in_data = d; in_weight = wt; in_width = 5'(iw); weight_width = 5'(ww);
    s_in = sa; s_weight = sw; in_last = last; in_valid = 1'b1;
    waits = 0; k = -1;
    for (int t = 0; t < 100; t++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        @(negedge clk);
        k = cyc;
        in_valid = 1'b0;
        return;
      end
      waits++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; errors++;
    $display("FAIL send_beat: in_ready never high within 100 cycles (got 0, want 1)");
  endtask

  task automatic wait_result(output logic [31:0] acc, output int at);
    acc = '0; at = -1;
    for (int t = 0; t < 100; t++) begin
      #1;
      if (out_valid) begin
        acc = out_acc;
        at = cyc;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL wait_result: out_valid never high within 100 cycles (got 0, want 1)");
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_acc !== 32'd0) begin errors++; $display("FAIL reset_out_acc: got %h want 0", out_acc); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_spatial();
    int k, waits, at;
    logic [31:0] acc;
    send_beat(16'h7F80, 16'h02FF, 8, 8, 1'b1, 1'b1, 1'b1, k, waits);
    wait_result(acc, at);
    checks++; if (acc !== 32'h0000017E) begin errors++; $display("FAIL s8_value: got %h want 0000017e", acc); end
    checks++; if (at !== k + 1) begin errors++; $display("FAIL s8_latency: got %0d want %0d", at - k, 1); end
    send_beat(16'hFFFF, 16'h5555, 2, 2, 1'b1, 1'b1, 1'b1, k, waits);
    wait_result(acc, at);
    checks++; if (acc !== 32'hFFFFFFF8) begin errors++; $display("FAIL s2_value: got %h want fffffff8", acc); end
  endtask

  task automatic test_temporal();
    int k, waits, at;
    logic [31:0] acc;
    send_beat(16'hFFFF, 16'hFFFF, 16, 16, 1'b0, 1'b0, 1'b1, k, waits);
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL u16_busy_%0d: in_ready got %b want 0", i, in_ready); end
      @(negedge clk);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL u16_final_ready: got %b want 1", in_ready); end
    wait_result(acc, at);
    checks++; if (acc !== 32'hFFFE0001) begin errors++; $display("FAIL u16_value: got %h want fffe0001", acc); end
    checks++; if (at !== k + 4) begin errors++; $display("FAIL u16_latency: got %0d want 4", at - k); end
    send_beat(16'hFFFF, 16'hFFFF, 16, 16, 1'b1, 1'b1, 1'b1, k, waits);
    wait_result(acc, at);
    checks++; if (acc !== 32'd1) begin errors++; $display("FAIL s16_value: got %h want 1", acc); end
  endtask

  task automatic test_back_to_back();
    int k, k2, waits, at;
    logic [31:0] acc;
    for (int b = 0; b < 3; b++) begin
      send_beat(16'h1111, 16'h2222, 4, 4, 1'b0, 1'b0, b == 2, k, waits);
      checks++; if (waits !== 0) begin errors++; $display("FAIL b2b_wait_%0d: got %0d want 0", b, waits); end
    end
    wait_result(acc, at);
    checks++; if (acc !== 32'd24) begin errors++; $display("FAIL b2b_value: got %0d want 24", acc); end
    // Two single-beat vectors back to back: consume and produce coincide.
    send_beat(16'h1111, 16'h2222, 4, 4, 1'b0, 1'b0, 1'b1, k, waits);
    send_beat(16'h1111, 16'h1111, 4, 4, 1'b0, 1'b0, 1'b1, k2, waits);
    wait_result(acc, at);
    checks++; if (acc !== 32'd8) begin errors++; $display("FAIL b2b_fresh_value: got %0d want 8", acc); end
    wait_result(acc, at);
    checks++; if (acc !== 32'd4) begin errors++; $display("FAIL b2b_second_value: got %0d want 4", acc); end
    checks++; if (at !== k2 + 1) begin errors++; $display("FAIL b2b_second_cycle: got %0d want %0d", at, k2 + 1); end
  endtask

  task automatic test_backpressure();
    int k, waits, at, kb;
    logic [31:0] acc;
    out_ready = 1'b0;
    send_beat(16'h0203, 16'h0405, 8, 8, 1'b0, 1'b0, 1'b1, k, waits);
    wait_result(acc, at);
    checks++; if (acc !== 32'd23) begin errors++; $display("FAIL bp_first: got %0d want 23", acc); end
    in_data = 16'h0102; in_weight = 16'h0304; in_width = 5'd8; weight_width = 5'd8;
    s_in = 1'b0; s_weight = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d: got %b want 0", i, in_ready); end
      checks++; if (out_acc !== 32'd23) begin errors++; $display("FAIL bp_hold_%0d: got %0d want 23", i, out_acc); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d: got %b want 1", i, out_valid); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    kb = cyc;
    in_valid = 1'b0;
    wait_result(acc, at);
    checks++; if (acc !== 32'd11) begin errors++; $display("FAIL bp_second: got %0d want 11", acc); end
    checks++; if (at !== kb + 1) begin errors++; $display("FAIL bp_second_cycle: got %0d want %0d", at, kb + 1); end
  endtask

  task automatic test_cfg_err();
    int k, waits, at;
    logic [31:0] acc;
    send_beat(16'h1234, 16'h5678, 3, 8, 1'b0, 1'b0, 1'b1, k, waits);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse: got %b want 1", cfg_err); end
    wait_result(acc, at);
    checks++; if (acc !== 32'd0) begin errors++; $display("FAIL cfg_err_result: got %h want 0", acc); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear: got %b want 0", cfg_err); end
    send_beat(16'hFFFF, 16'hFFFF, 0, 8, 1'b0, 1'b0, 1'b0, k, waits);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_w0: got %b want 1", cfg_err); end
    send_beat(16'h0102, 16'h0304, 8, 8, 1'b0, 1'b0, 1'b1, k, waits);
    wait_result(acc, at);
    checks++; if (acc !== 32'd11) begin errors++; $display("FAIL cfg_err_mixed: got %0d want 11", acc); end
  endtask

  task automatic test_random();
    int widths[5] = '{1, 2, 4, 8, 16};
    int k, waits, at, prev_passes, nbeats, iw, ww;
    bit sa, sw;
    logic [15:0] d, wt;
    logic [31:0] exp_sum, acc;
    for (int v = 0; v < 40; v++) begin
      nbeats = $urandom_range(1, 4);
      exp_sum = '0;
      prev_passes = 0;
      for (int b = 0; b < nbeats; b++) begin
        iw = widths[$urandom_range(0, 4)];
        ww = widths[$urandom_range(0, 4)];
        sa = 1'($urandom_range(0, 1));
        sw = 1'($urandom_range(0, 1));
        d  = 16'($urandom);
        wt = 16'($urandom);
        exp_sum = exp_sum + model_dot(d, wt, iw, ww, sa, sw);
        send_beat(d, wt, iw, ww, sa, sw, b == nbeats - 1, k, waits);
        checks++;
        if (waits !== ((b == 0) ? 0 : prev_passes - 1)) begin
          errors++;
          $display("FAIL rand_throughput v%0d b%0d: waited %0d want %0d", v, b, waits, (b == 0) ? 0 : prev_passes - 1);
        end
        prev_passes = model_passes(iw, ww);
      end
      wait_result(acc, at);
      checks++;
      if (acc !== exp_sum) begin
        errors++;
        $display("FAIL rand_value v%0d: got %h want %h", v, acc, exp_sum);
      end
      checks++;
      if (at !== k + prev_passes) begin
        errors++;
        $display("FAIL rand_latency v%0d: got %0d want %0d", v, at - k, prev_passes);
      end
    end
  endtask

  task automatic test_reset_midpass();
    int k, waits, at;
    logic [31:0] acc;
    send_beat(16'hFFFF, 16'hFFFF, 16, 16, 1'b0, 1'b0, 1'b1, k, waits);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    checks++; if (out_acc !== 32'd0) begin errors++; $display("FAIL midrst_acc: got %h want 0", out_acc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(16'h0003, 16'h0005, 8, 8, 1'b0, 1'b0, 1'b1, k, waits);
    wait_result(acc, at);
    checks++; if (acc !== 32'd15) begin errors++; $display("FAIL midrst_after: got %0d want 15", acc); end
  endtask

  initial begin
    test_reset();
    test_spatial();
    test_temporal();
    test_back_to_back();
    test_backpressure();
    test_cfg_err();
    test_random();
    test_reset_midpass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
